// File: rtl/avalon_gpio_pulse.sv
// avalon_gpio_pulse: Avalon-MM GPIO slave with set/clear, timed pulse engine and input edge-capture interrupt
module avalon_gpio_pulse #(
  parameter int WIDTH = 8,
  parameter int PULSE_CYCLES = 16,
  parameter int EDGE_TYPE = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  localparam int CW = $clog2(PULSE_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(PULSE_CYCLES - 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d, mask_q, mask_d, cap_q, cap_d, pmask_q, pmask_d;
  logic [WIDTH-1:0] sync1_q, in_sync_q, in_prev_q, edge_det, wd;
  logic [CW-1:0] cnt_q, cnt_d;
  logic wr, expire, pulse_go, unused_wd;
  assign wr = chipselect & ~write_n;
  assign wd = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign pulse_go = wr & (address == 3'd6) & (|wd);
  assign expire = (state_q == BUSY) & (cnt_q == '0);
  assign edge_det = EDGE_TYPE == 0 ? in_sync_q & ~in_prev_q :
                    EDGE_TYPE == 1 ? ~in_sync_q & in_prev_q : in_sync_q ^ in_prev_q;
  // Host writes to the out register override an expiry clear landing in the same cycle
  always_comb begin
    out_d = wr && address == 3'd0 ? wd :
            wr && address == 3'd4 ? out_q | wd :
            wr && address == 3'd5 ? out_q & ~wd :
            pulse_go ? out_q | wd :
            expire ? out_q & ~pmask_q : out_q;
    pmask_d = pulse_go ? pmask_q | wd : expire ? '0 : pmask_q;
    state_d = pulse_go ? BUSY : expire ? IDLE : state_q;
    cnt_d = pulse_go ? RELOAD : (state_q == BUSY && !expire) ? cnt_q - CW'(1) : cnt_q;
    mask_d = wr && address == 3'd2 ? wd : mask_q;
    cap_d = (cap_q & ~(wr && address == 3'd3 ? wd : '0)) | edge_det;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q <= RESET_VALUE;
      mask_q <= '0;
      cap_q <= '0;
      pmask_q <= '0;
      cnt_q <= '0;
      state_q <= IDLE;
      sync1_q <= '0;
      in_sync_q <= '0;
      in_prev_q <= '0;
    end else begin
      out_q <= out_d;
      mask_q <= mask_d;
      cap_q <= cap_d;
      pmask_q <= pmask_d;
      cnt_q <= cnt_d;
      state_q <= state_d;
      sync1_q <= in_port;
      in_sync_q <= sync1_q;
      in_prev_q <= in_sync_q;
    end
  end
  always_comb begin
    case (address)
      3'd0: readdata = 32'(out_q);
      3'd1: readdata = 32'(in_sync_q);
      3'd2: readdata = 32'(mask_q);
      3'd3: readdata = 32'(cap_q);
      3'd6: readdata = 32'(pmask_q);
      3'd7: readdata = {31'b0, state_q == BUSY};
      default: readdata = '0;
    endcase
  end
  assign out_port = out_q;
  assign irq = |(cap_q & mask_q);
endmodule

// File: tb/tb_avalon_gpio_pulse.sv
// tb_avalon_gpio_pulse: directed scoreboard bench for avalon_gpio_pulse (8-bit and 1-bit builds)
module tb_avalon_gpio_pulse;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [2:0] address = '0;
  logic chipselect = 1'b0, cs1 = 1'b0, write_n = 1'b1;
  logic [31:0] writedata = '0, readdata, readdata1, r;
  logic [7:0] out_port, in_port = '0;
  logic [0:0] out_port1, in_port1 = '0;
  logic irq, irq1;
  int checks = 0, failures = 0;
  logic [31:0] exp_q[$];
  string tag_q[$];
  always #5 clk = ~clk;
  avalon_gpio_pulse #(.WIDTH(8), .PULSE_CYCLES(16), .EDGE_TYPE(0), .RESET_VALUE(8'hA5)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata), .out_port(out_port), .in_port(in_port), .irq(irq));
  avalon_gpio_pulse #(.WIDTH(1)) u1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs1), .write_n(write_n),
    .writedata(writedata), .readdata(readdata1), .out_port(out_port1), .in_port(in_port1), .irq(irq1));
  task automatic expect_v(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask
  task automatic check(input logic [31:0] obs);
    string t;
    logic [31:0] e;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask
  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    chipselect = 1'b1;
    #1 d = readdata;
    chipselect = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    expect_v("rst_out", 32'hA5); check(32'(out_port));
    expect_v("rst_irq", 32'h0); check(32'(irq));
    for (int a = 0; a < 8; a++) begin
      expect_v($sformatf("rst_rd%0d", a), a == 0 ? 32'hA5 : 32'h0);
      rd(3'(a), r); check(r);
    end
    expect_v("data_0f", 32'h0F); wr(3'd0, 32'h0F); check(32'(out_port));
    expect_v("outset_3f", 32'h3F); wr(3'd4, 32'h30); check(32'(out_port));
    expect_v("outclr_3c", 32'h3C); wr(3'd5, 32'h03); check(32'(out_port));
    expect_v("rd_data", 32'h3C); rd(3'd0, r); check(r);
    expect_v("rd_outset", 32'h0); rd(3'd4, r); check(r);
    expect_v("rd_outclr", 32'h0); rd(3'd5, r); check(r);
    wr(3'd0, 32'h0);
    expect_v("pulse_start", 32'h01); wr(3'd6, 32'h01); check(32'(out_port));
    expect_v("pulse_busy0", 32'h1); rd(3'd7, r); check(r);
    for (int k = 1; k < 16; k++) begin
      tick();
      expect_v($sformatf("pulse_hi%0d", k), 32'h01); check(32'(out_port));
      expect_v($sformatf("pulse_busy%0d", k), 32'h1); rd(3'd7, r); check(r);
    end
    tick();
    expect_v("pulse_end", 32'h00); check(32'(out_port));
    expect_v("pulse_idle", 32'h0); rd(3'd7, r); check(r);
    expect_v("retrig_start", 32'h01); wr(3'd6, 32'h01); check(32'(out_port));
    for (int k = 1; k < 10; k++) tick();
    expect_v("retrig_both", 32'h03); wr(3'd6, 32'h02); check(32'(out_port));
    expect_v("retrig_pmask", 32'h03); rd(3'd6, r); check(r);
    for (int k = 1; k < 16; k++) begin
      tick();
      expect_v($sformatf("retrig_hi%0d", k), 32'h03); check(32'(out_port));
    end
    tick();
    expect_v("retrig_end", 32'h00); check(32'(out_port));
    expect_v("retrig_pmask0", 32'h0); rd(3'd6, r); check(r);
    expect_v("coll_data", 32'h02); wr(3'd0, 32'h02); check(32'(out_port));
    expect_v("coll_pulse", 32'h03); wr(3'd6, 32'h01); check(32'(out_port));
    for (int k = 1; k < 16; k++) tick();
    expect_v("coll_clr", 32'h02); wr(3'd5, 32'h01); check(32'(out_port));
    expect_v("coll_busy", 32'h0); rd(3'd7, r); check(r);
    expect_v("coll_pmask", 32'h0); rd(3'd6, r); check(r);
    tick();
    expect_v("coll_hold", 32'h02); check(32'(out_port));
    expect_v("mid_pulse", 32'h0A); wr(3'd6, 32'h08); check(32'(out_port));
    tick(); tick(); tick();
    reset_n = 1'b0;
    #1;
    expect_v("async_rst_out", 32'hA5); check(32'(out_port));
    expect_v("async_rst_pmask", 32'h0); rd(3'd6, r); check(r);
    expect_v("async_rst_busy", 32'h0); rd(3'd7, r); check(r);
    tick();
    reset_n = 1'b1;
    tick();
    wr(3'd2, 32'h04);
    in_port = 8'h04;
    tick(); tick();
    expect_v("in_2cyc", 32'h04); rd(3'd1, r); check(r);
    expect_v("cap_not_yet", 32'h0); rd(3'd3, r); check(r);
    expect_v("irq_not_yet", 32'h0); check(32'(irq));
    tick();
    expect_v("cap_rise", 32'h04); rd(3'd3, r); check(r);
    expect_v("irq_rise", 32'h1); check(32'(irq));
    in_port = 8'h00;
    tick(); tick(); tick(); tick();
    expect_v("in_fall", 32'h0); rd(3'd1, r); check(r);
    expect_v("cap_fall", 32'h04); rd(3'd3, r); check(r);
    expect_v("irq_clr", 32'h0); wr(3'd3, 32'h04); check(32'(irq));
    expect_v("cap_clr", 32'h0); rd(3'd3, r); check(r);
    in_port = 8'h04;
    tick(); tick();
    expect_v("set_wins_irq", 32'h1); wr(3'd3, 32'h04); check(32'(irq));
    expect_v("set_wins_cap", 32'h04); rd(3'd3, r); check(r);
    in_port = 8'h5A;
    tick();
    expect_v("in_1cyc_old", 32'h04); rd(3'd1, r); check(r);
    tick();
    expect_v("in_5a", 32'h5A); rd(3'd1, r); check(r);
    tick();
    expect_v("cap_5e", 32'h5E); rd(3'd3, r); check(r);
    expect_v("irq_masked", 32'h0); wr(3'd3, 32'h04); check(32'(irq));
    expect_v("irq_unmask", 32'h1); wr(3'd2, 32'h10); check(32'(irq));
    address = 3'd0;
    writedata = 32'hFFFF_FFFE;
    cs1 = 1'b1;
    write_n = 1'b0;
    tick();
    cs1 = 1'b0;
    write_n = 1'b1;
    expect_v("w1_out0", 32'h0); check(32'(out_port1));
    expect_v("w1_rd0", 32'h0); #1 check(readdata1);
    writedata = 32'hFFFF_FFFF;
    cs1 = 1'b1;
    write_n = 1'b0;
    tick();
    cs1 = 1'b0;
    write_n = 1'b1;
    expect_v("w1_out1", 32'h1); check(32'(out_port1));
    expect_v("w1_rd1", 32'h1); #1 check(readdata1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/avalon_gpio_pulse.md
# avalon_gpio_pulse

Parametrised Avalon-MM general-purpose I/O slave for the SoC: WIDTH output bits with atomic set/clear, a hardware-timed pulse generator for reset strobes such as the USB controller reset, and WIDTH synchronised input bits with edge capture and a maskable interrupt. It sits on the Nios II data master interconnect as a zero-wait-state slave, next to the other PIO peripherals, and drives board-level control pins directly.

## Interface

- WIDTH, 8, number of output and input bits, 1..32
- PULSE_CYCLES, 16, length of a hardware pulse in clk cycles, >= 1, counter width clog2(PULSE_CYCLES+1)
- EDGE_TYPE, 0, edge-capture mode: 0 = rising, 1 = falling, 2 = any
- RESET_VALUE, 0, reset value of out_port, WIDTH bits

- clk  in  1  system clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  word register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe, valid with chipselect
- writedata  in  32  write data; bits [31:WIDTH] ignored
- readdata  out  32  read data, combinational from address; bits [31:WIDTH] zero
- out_port  out  WIDTH  registered output pins
- in_port  in  WIDTH  asynchronous input pins
- irq  out  1  level interrupt, high while any unmasked capture bit is set

## Operation

- Write = chipselect & ~write_n. Reads have no side effects.
- Register map (word addresses):
  - 0 DATA: R/W; write loads out register; read returns out register
  - 1 IN: RO; returns synchronised inputs in_sync
  - 2 IRQMASK: R/W, WIDTH bits
  - 3 EDGECAP: R, write-1-to-clear
  - 4 OUTSET: WO; out |= writedata; reads 0
  - 5 OUTCLR: WO; out &= ~writedata; reads 0
  - 6 PULSE: W starts pulse; read returns current pulse_mask
  - 7 STATUS: RO; bit0 = pulse_busy
- Pulse engine: pulse_mask (WIDTH), counter, pulse_busy.
  - IDLE (busy=0): write to PULSE with nonzero data: out |= data, pulse_mask = data, counter = PULSE_CYCLES-1, go BUSY. Zero data: no effect.
  - BUSY: counter decrements each cycle. At counter==0: out &= ~pulse_mask, pulse_mask = 0, go IDLE.
  - Write to PULSE while BUSY: out |= data, pulse_mask |= data, counter reloads PULSE_CYCLES-1 (retrigger extends all pulsed bits).
- Input path: two-flop synchroniser in_port -> in_sync; third flop in_prev. Edge detected per bit: rising = in_sync & ~in_prev; falling = ~in_sync & in_prev; any = XOR.
- EDGECAP bit sets on detected edge; write-1 clears; set wins over clear in the same cycle.
- irq = |(EDGECAP & IRQMASK), driven from registers only (glitch-free).
- Simultaneous events:
  - DATA/OUTSET/OUTCLR write in the pulse expiry cycle: write result is final, expiry clear is not applied, pulse ends (busy=0, pulse_mask=0).
  - DATA/OUTSET/OUTCLR write while BUSY (not at expiry): applied normally; expiry later still clears pulse_mask bits.
  - PULSE write in the expiry cycle: treated as retrigger; expiry suppressed.
- Reset: out = RESET_VALUE, IRQMASK = 0, EDGECAP = 0, in_sync/in_prev = 0, pulse_mask = 0, counter = 0, busy = 0, irq = 0. Reset mid-pulse aborts the pulse immediately.

## Timing

- Register writes take effect at the clk edge of the write cycle; out_port reflects them the following cycle.
- readdata valid in the same cycle as chipselect/address (read latency 0, no wait states).
- Pulse: out_port bits high for exactly PULSE_CYCLES cycles after the write edge; busy high for the same window.
- Input to IN register: 2 cycles. Input edge to EDGECAP/irq: 3 cycles.
- EDGECAP clear to irq low: 1 cycle.
- No combinational path from in_port to any output.

## Test plan

- Reset with RESET_VALUE=8'hA5 -> out_port=8'hA5, irq=0, STATUS=0, all readable registers at reset values; assert reset_n mid-pulse -> out_port returns to 8'hA5 asynchronously.
- Write DATA=8'h0F, OUTSET=8'h30, OUTCLR=8'h03 -> out_port 8'h0F, 8'h3F, 8'h3C on successive cycles; readback addr0 = 8'h3C, addr4/5 read 0.
- PULSE_CYCLES=16, write PULSE=8'h01 -> bit0 high for exactly 16 cycles, STATUS.bit0=1 for those cycles; retrigger with 8'h02 at cycle 10 -> both bits drop together 16 cycles after the retrigger.
- Write OUTCLR=8'h01 in the expiry cycle of a pulse on bit0 with bit1 also set by DATA -> bit1 stays 1, bit0 0, busy=0.
- EDGE_TYPE=0, IRQMASK=8'h04, rising edge on in_port[2] -> EDGECAP=8'h04 and irq=1 three cycles later; falling edge -> no new capture; write EDGECAP=8'h04 -> irq=0 next cycle; edge coinciding with the clear -> bit remains set.
- in_port=8'h5A held -> IN reads 8'h5A after 2 cycles; WIDTH=1 build: readdata[31:1]=0, writedata[31:1] ignored.
